ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 command sender for the keyboard port.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Sequences the shared PS/2 clock/data lines through inhibit, request-to-send, bit shifting and ACK check.
- While it owns the bus it asserts rx_inhibit, so the existing scan-code receiver ignores line activity.

Parameters:
- INHIBIT_CYCLES, 2600: clock-low hold before request-to-send (≥100 µs at 25 MHz).
- FILTER_LEN, 8: consecutive equal samples required before a filtered line level changes.
- TIMEOUT_CYCLES, 50000: maximum gap between device clock falling edges, or before the first one (2 ms).

Ports:
- clk_25MHz  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- ps2_clk_in  in  1  raw PS/2 clock line level.
- ps2_data_in  in  1  raw PS/2 data line level.
- ps2_clk_oe  out  1  1 = pull PS/2 clock low (open-drain).
- ps2_data_oe  out  1  1 = pull PS/2 data low (open-drain).
- cmd_valid  in  1  command request.
- cmd_byte  in  8  command to send.
- cmd_ready  out  1  block can accept a command.
- rx_inhibit  out  1  bus owned by transmitter; receiver must ignore edges.
- done  out  1  one-cycle completion pulse.
- ack_ok  out  1  valid with done; device acknowledged.
- err  out  1  valid with done; timeout or missing ACK.

Behaviour:
- Reset state (asynchronous): state IDLE; ps2_clk_oe=0, ps2_data_oe=0, rx_inhibit=0, done=0, ack_ok=0, err=0, cmd_ready=1.
- Line conditioning:
  - Each raw line goes through a 2-flop synchronizer, then a FILTER_LEN filter.
  - Falling edge = filtered clock going 1→0, one cycle late relative to the filter.
- Accept: cmd_valid && cmd_ready.
  - Latch cmd_byte.
  - Compute parity = ~^cmd_byte (odd parity).
  - Go to INHIBIT.
  - An in-progress device transmission is aborted by design; the keyboard retransmits.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles. On the last cycle, ps2_data_oe=1 (start bit). Then go to RTS.
- RTS: ps2_clk_oe=0, ps2_data_oe=1. Wait for the first falling edge. Clear the timeout counter, go to SEND with bit index 0.
- SEND: on each falling edge drive the next bit, with ps2_data_oe = ~bit.
  - Edges 1–8: data bits 0..7, LSB first.
  - Edge 9: parity.
  - Edge 10: stop bit (ps2_data_oe=0).
  - After edge 10, go to ACK.
- ACK: at the 11th falling edge sample filtered data.
  - 0: ack_ok=1.
  - 1: err=1.
  - Then go to WAIT_IDLE.
- WAIT_IDLE: wait until filtered clock and data are both 1, then go to DONE.
- DONE: done=1 for one cycle, with ack_ok and err held valid in that cycle. Next cycle go to IDLE and clear ack_ok and err.
- Timeout: a 17-bit counter runs in RTS, SEND, ACK and WAIT_IDLE and clears on each falling edge.
  - Reaching TIMEOUT_CYCLES: release both lines immediately, set err=1, ack_ok=0, go to DONE.
- rx_inhibit=1 in every state except IDLE.
- cmd_ready=1 only in IDLE. cmd_valid held while busy is ignored and cannot be accepted twice.
- Line safety: both oe signals are registered and glitch-free. ps2_data_oe is never asserted unless in INHIBIT-last-cycle, RTS or SEND.
- rst mid-operation: lines are released asynchronously, the command is dropped, and no done pulse is issued.

Decomposition:
- Package ps2_pkg:
  - state enum (IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, DONE);
  - odd-parity function;
  - command constants CMD_SET_LED=8'hED, CMD_RESET=8'hFF;
  - default timing constants.
- Sub-module ps2_line_filter (synchronizer + FILTER_LEN filter + falling-edge pulse), instantiated for the clock and data lines. The receiver will reuse it.

Test Plan:
1. cmd_byte=8'hED, device model ACKs -> ps2_clk_oe high exactly 2600 cycles; bits sampled on device rising edges are 0(start),1,0,1,1,0,1,1,1, parity 1, stop 1; done with ack_ok=1, err=0.
2. cmd_byte=8'h07 -> parity bit 0; cmd_byte=8'hFF -> parity bit 1; both ACKed with ack_ok=1.
3. Device drives data high at the 11th falling edge -> done with ack_ok=0, err=1; lines released; cmd_ready=1 in the cycle after done.
4. Device never clocks after RTS -> exactly 50000 cycles after entering RTS both oe=0, done with err=1.
5. rst asserted at SEND bit 4 -> ps2_clk_oe=ps2_data_oe=0 without waiting for a clock edge; no done pulse; cmd_ready=1 after rst deasserts.
6. 3-cycle glitch low on ps2_clk_in during SEND produces no bit advance; cmd_valid held high throughout test 1 produces exactly one transaction before returning to IDLE.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, command codes, default timing
// and the odd-parity helper used when framing a host command.
package ps2_pkg;

  localparam int DEF_INHIBIT_CYCLES = 2600;
  localparam int DEF_FILTER_LEN     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 50000;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE,
    DONE
  } tx_state_e;

  function automatic logic oddParity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 line: 2-flop synchronizer, FILTER_LEN-sample
// debounce and a registered falling-edge pulse of the filtered level.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_levelDly;
  logic          r_fall;

  // Idle PS/2 lines float high, so everything resets to the released level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync     <= 2'b11;
      r_cnt      <= '0;
      r_level    <= 1'b1;
      r_levelDly <= 1'b1;
      r_fall     <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_levelDly <= r_level;
      r_fall     <= r_levelDly & ~r_level;
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command sender: inhibits the bus, requests to send,
// shifts the framed byte out on device clock edges and checks the ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       i_clk_25MHz,
  input  logic       i_rst,
  input  logic       i_ps2_clk_in,
  input  logic       i_ps2_data_in,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe,
  input  logic       i_cmd_valid,
  input  logic [7:0] i_cmd_byte,
  output logic       o_cmd_ready,
  output logic       o_rx_inhibit,
  output logic       o_done,
  output logic       o_ack_ok,
  output logic       o_err
);

  localparam logic [16:0] START_BIT_AT = 17'(INHIBIT_CYCLES - 2);
  localparam logic [16:0] INHIBIT_LAST = 17'(INHIBIT_CYCLES - 1);
  localparam logic [16:0] TIMEOUT_LAST = 17'(TIMEOUT_CYCLES - 1);

  tx_state_e   r_state;
  logic [16:0] r_cnt;
  logic [9:0]  r_frame;
  logic [3:0]  r_bitIdx;
  logic        r_clkOe;
  logic        r_dataOe;
  logic        r_rxInhibit;
  logic        r_done;
  logic        r_ackOk;
  logic        r_err;
  logic        r_cmdReady;

  logic w_clkLevel;
  logic w_clkFall;
  logic w_dataLevel;
  logic w_dataFallUnused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clkFilter (
    .i_clk   (i_clk_25MHz),
    .i_rst   (i_rst),
    .i_raw   (i_ps2_clk_in),
    .o_level (w_clkLevel),
    .o_fall  (w_clkFall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dataFilter (
    .i_clk   (i_clk_25MHz),
    .i_rst   (i_rst),
    .i_raw   (i_ps2_data_in),
    .o_level (w_dataLevel),
    .o_fall  (w_dataFallUnused)
  );

  // r_frame holds {stop, parity, data} and shifts right as bits go out; the
  // first device falling edge (still in RTS) already drives data bit 0.
  always_ff @(posedge i_clk_25MHz or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_frame     <= '0;
      r_bitIdx    <= '0;
      r_clkOe     <= 1'b0;
      r_dataOe    <= 1'b0;
      r_rxInhibit <= 1'b0;
      r_done      <= 1'b0;
      r_ackOk     <= 1'b0;
      r_err       <= 1'b0;
      r_cmdReady  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_cmd_valid && r_cmdReady) begin
            r_frame     <= {1'b1, oddParity(i_cmd_byte), i_cmd_byte};
            r_cnt       <= '0;
            r_clkOe     <= 1'b1;
            r_rxInhibit <= 1'b1;
            r_cmdReady  <= 1'b0;
            r_state     <= INHIBIT;
          end
        end
        INHIBIT: begin
          r_cnt <= r_cnt + 17'd1;
          if (r_cnt == START_BIT_AT) r_dataOe <= 1'b1;
          if (r_cnt == INHIBIT_LAST) begin
            r_clkOe <= 1'b0;
            r_cnt   <= '0;
            r_state <= RTS;
          end
        end
        DONE: begin
          r_done      <= 1'b0;
          r_ackOk     <= 1'b0;
          r_err       <= 1'b0;
          r_rxInhibit <= 1'b0;
          r_cmdReady  <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_cnt <= w_clkFall ? '0 : r_cnt + 17'd1;
          if (!w_clkFall && r_cnt == TIMEOUT_LAST) begin
            r_clkOe  <= 1'b0;
            r_dataOe <= 1'b0;
            r_ackOk  <= 1'b0;
            r_err    <= 1'b1;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end else begin
            case (r_state)
              RTS: begin
                if (w_clkFall) begin
                  r_dataOe <= ~r_frame[0];
                  r_frame  <= {1'b0, r_frame[9:1]};
                  r_bitIdx <= '0;
                  r_state  <= SEND;
                end
              end
              SEND: begin
                if (w_clkFall) begin
                  r_dataOe <= ~r_frame[0];
                  r_frame  <= {1'b0, r_frame[9:1]};
                  r_bitIdx <= r_bitIdx + 4'd1;
                  if (r_bitIdx == 4'd8) r_state <= ACK;
                end
              end
              ACK: begin
                if (w_clkFall) begin
                  r_ackOk <= ~w_dataLevel;
                  r_err   <= w_dataLevel;
                  r_state <= WAIT_IDLE;
                end
              end
              WAIT_IDLE: begin
                if (w_clkLevel && w_dataLevel) begin
                  r_done  <= 1'b1;
                  r_state <= DONE;
                end
              end
              default: begin
              end
            endcase
          end
        end
      endcase
    end
  end

  assign o_ps2_clk_oe  = r_clkOe;
  assign o_ps2_data_oe = r_dataOe;
  assign o_cmd_ready   = r_cmdReady;
  assign o_rx_inhibit  = r_rxInhibit;
  assign o_done        = r_done;
  assign o_ack_ok      = r_ackOk;
  assign o_err         = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus with a behavioural keyboard that
// clocks the host frame in, samples it, and ACKs or NACKs it.
module tb_ps2_host_tx;

  localparam int INHIBIT = 2600;
  localparam int TIMEOUT = 12000;
  localparam int HALF    = 30;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmdValid;
  logic [7:0] cmdByte;
  logic       devClkLow;
  logic       devDataLow;
  logic       clkOe, dataOe, cmdReady, rxInhibit, done, ackOk, err;

  wire ps2Clk  = ~(clkOe | devClkLow);
  wire ps2Data = ~(dataOe | devDataLow);

  int   checks = 0;
  int   errors = 0;
  int   doneCount = 0;
  int   acceptCount = 0;
  logic clkOeDly = 1'b0;

  always #20 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INHIBIT),
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .i_clk_25MHz   (clk),
    .i_rst         (rst),
    .i_ps2_clk_in  (ps2Clk),
    .i_ps2_data_in (ps2Data),
    .o_ps2_clk_oe  (clkOe),
    .o_ps2_data_oe (dataOe),
    .i_cmd_valid   (cmdValid),
    .i_cmd_byte    (cmdByte),
    .o_cmd_ready   (cmdReady),
    .o_rx_inhibit  (rxInhibit),
    .o_done        (done),
    .o_ack_ok      (ackOk),
    .o_err         (err)
  );

  // Each start of a clock-inhibit marks one accepted command.
  always @(negedge clk) begin
    clkOeDly <= clkOe;
    if (clkOe === 1'b1 && clkOeDly === 1'b0) acceptCount <= acceptCount + 1;
    if (done === 1'b1) doneCount <= doneCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic v);
    @(negedge clk);
    cmdByte  = b;
    cmdValid = v;
  endtask

  // Start bit, 8 data bits LSB first, odd parity, stop bit.
  function automatic logic [10:0] frameModel(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Keyboard side: measure the inhibit, then clock the frame in, sampling on
  // each rising edge; optionally glitch, stop early with clock low, or NACK.
  task automatic runDevice(input logic nackHigh, input int glitchAfter, input int stopAfter,
                           output logic [10:0] bits, output int inhLen, output int startOeCycles);
    int n;
    bits = '0;
    inhLen = 0;
    startOeCycles = 0;
    n = 0;
    while (clkOe !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("inhibitStart", clkOe, 1);
    if (clkOe !== 1'b1) return;
    checkOutput("busyFlags", {rxInhibit, cmdReady}, 2'b10);
    while (clkOe === 1'b1 && inhLen < 10000) begin
      inhLen++;
      if (dataOe === 1'b1) startOeCycles++;
      @(negedge clk);
    end
    waitCycles(20);
    bits[0] = ps2Data;
    for (int k = 1; k <= 10; k++) begin
      devClkLow = 1'b1;
      waitCycles(HALF);
      if (k == stopAfter) return;
      devClkLow = 1'b0;
      bits[k] = ps2Data;
      if (k == glitchAfter) begin
        waitCycles(10);
        devClkLow = 1'b1;
        waitCycles(3);
        devClkLow = 1'b0;
        waitCycles(HALF - 13);
      end else begin
        waitCycles(HALF);
      end
    end
    if (!nackHigh) devDataLow = 1'b1;
    waitCycles(HALF);
    devClkLow = 1'b1;
    waitCycles(HALF);
    devClkLow = 1'b0;
    waitCycles(2);
    devDataLow = 1'b0;
  endtask

  task automatic waitDone(output logic seen, output logic a, output logic e, output logic [1:0] oes);
    seen = 1'b0;
    a = 1'b0;
    e = 1'b0;
    oes = 2'b11;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        a = ackOk;
        e = err;
        oes = {clkOe, dataOe};
      end
    end
  endtask

  // cmd_valid stays high for the whole transaction and drops at done.
  task automatic runTransaction(input string name, input logic [7:0] b, input logic nackHigh,
                                input int glitchAfter);
    logic [10:0] bits;
    int inhLen, startOe, d0, a0;
    logic seen, a, e;
    logic [1:0] oes;
    d0 = doneCount;
    a0 = acceptCount;
    applyStimulus(b, 1'b1);
    runDevice(nackHigh, glitchAfter, 0, bits, inhLen, startOe);
    waitDone(seen, a, e, oes);
    cmdValid = 1'b0;
    checkOutput({name, ".inhibitLen"}, inhLen, INHIBIT);
    checkOutput({name, ".startBitCycles"}, startOe, 1);
    checkOutput({name, ".bits"}, bits, frameModel(b));
    checkOutput({name, ".done"}, seen, 1);
    checkOutput({name, ".ackOk"}, a, !nackHigh);
    checkOutput({name, ".err"}, e, nackHigh);
    checkOutput({name, ".released"}, oes, 2'b00);
    @(negedge clk);
    checkOutput({name, ".readyAfterDone"}, {cmdReady, rxInhibit}, 2'b10);
    waitCycles(20);
    checkOutput({name, ".oneTransaction"}, (doneCount - d0) * 16 + (acceptCount - a0), 17);
  endtask

  initial begin
    logic [10:0] bits;
    logic [10:0] expBits;
    logic [7:0]  rb;
    int inhLen, startOe, n, d0;

    rst = 1'b1;
    cmdValid = 1'b0;
    cmdByte = 8'h00;
    devClkLow = 1'b0;
    devDataLow = 1'b0;
    waitCycles(5);
    checkOutput("resetState", {clkOe, dataOe, rxInhibit, done, ackOk, err, cmdReady}, 7'b0000001);
    rst = 1'b0;
    waitCycles(20);

    runTransaction("setLed", 8'hED, 1'b0, 0);
    runTransaction("parity0", 8'h07, 1'b0, 0);
    runTransaction("parity1", 8'hFF, 1'b0, 0);
    runTransaction("nack", 8'hF3, 1'b1, 0);
    runTransaction("glitch", 8'h5A, 1'b0, 4);
    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom_range(0, 255));
      runTransaction($sformatf("rand%0d", i), rb, 1'($urandom_range(0, 1)), 0);
    end

    // Reset while the host is driving data bit 4 and the device holds clock low.
    d0 = doneCount;
    expBits = frameModel(8'hA5);
    applyStimulus(8'hA5, 1'b1);
    runDevice(1'b0, 0, 5, bits, inhLen, startOe);
    cmdValid = 1'b0;
    checkOutput("rst.partialBits", bits[4:0], expBits[4:0]);
    checkOutput("rst.preState", {clkOe, dataOe, rxInhibit}, 3'b011);
    #5 rst = 1'b1;
    #1 checkOutput("rst.released", {clkOe, dataOe, cmdReady, rxInhibit}, 4'b0010);
    @(negedge clk);
    devClkLow = 1'b0;
    waitCycles(3);
    rst = 1'b0;
    waitCycles(50);
    checkOutput("rst.readyAfter", {cmdReady, clkOe, dataOe}, 3'b100);
    checkOutput("rst.noDone", doneCount - d0, 0);

    // Device never clocks: the host must give up exactly TIMEOUT cycles into RTS.
    applyStimulus(8'hF4, 1'b1);
    n = 0;
    while (clkOe !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (clkOe === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    cmdValid = 1'b0;
    checkOutput("to.rtsEntered", {clkOe, dataOe}, 2'b01);
    n = 0;
    while (dataOe === 1'b1 && n < TIMEOUT + 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("to.cycles", n, TIMEOUT);
    checkOutput("to.doneErr", {done, ackOk, err, clkOe}, 4'b1010);
    waitCycles(2);
    checkOutput("to.idle", {cmdReady, rxInhibit}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
